// File: rtl/load_pkg.sv
// Shared definitions for the load/writeback unit: state encoding, RISC-V
// load funct3 codes, data width and small decode helpers.
// Optional build macro: MISALIGN_TRAP_EN (see load_writeback_unit).
package load_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    function automatic logic f3_supported(input logic [2:0] funct3);
        return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
               (funct3 == F3_LBU) || (funct3 == F3_LHU);
    endfunction

    // Halfword needs addr[0]=0, word needs addr[1:0]=0; bytes are always aligned.
    function automatic logic f3_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        return (((funct3 == F3_LH) || (funct3 == F3_LHU)) && offset[0]) ||
               ((funct3 == F3_LW) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/load_extend.sv
// Lane select and sign/zero extension of a loaded memory word.
module load_extend
    import load_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        offset,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] shifted;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;

    // Byte lane at 8*offset, halfword lane at 16*offset[1].
    always_comb begin
        shifted  = rdata >> {offset, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extension by load type; unsupported codes never reach writeback.
    always_comb begin
        data = '0;
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {24'h0, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data = {16'h0, half_sel};
            F3_LW:   data = rdata;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/load_writeback_unit.sv
// Load/writeback unit: accepts one load, fetches the word from data memory,
// extends it and writes the register file for one cycle.
// Optional build macro: MISALIGN_TRAP_EN -- when defined, misaligned LH/LHU/LW
// are rejected with an ld_err pulse instead of reading the aligned word.
//
// state  | meaning
// IDLE   | ready for a new load; rejected loads pulse ld_err from here
// REQ    | mem_req held with stable mem_addr until mem_gnt
// WAIT   | waiting for mem_rvalid, extended data latched on arrival
// WB     | single register-file write cycle (suppressed for rd=0)
module load_writeback_unit
    import load_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [2:0]        ld_funct3,
    input  logic [31:0]       ld_addr,
    input  logic [4:0]        ld_rd,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [31:0]       mem_addr,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              WE3,
    output logic [4:0]        A3,
    output logic [DATA_W-1:0] WD3,
    output logic              busy,
    output logic              ld_err
);

    logic [1:0]        state;
    logic [31:0]       addr_q;
    logic [2:0]        funct3_q;
    logic [4:0]        rd_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;
    logic [DATA_W-1:0] ext_data;
    logic              reject;

    load_extend u_extend (
        .funct3 (funct3_q),
        .offset (addr_q[1:0]),
        .rdata  (mem_rdata),
        .data   (ext_data)
    );

    // Decide whether an incoming load is turned away without a memory access.
    always_comb begin
`ifdef MISALIGN_TRAP_EN
        reject = !f3_supported(ld_funct3) || f3_misaligned(ld_funct3, ld_addr[1:0]);
`else
        reject = !f3_supported(ld_funct3);
`endif
    end

    // Transaction FSM and captured request fields.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            rd_q     <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ld_valid) begin
                        if (reject) begin
                            err_q <= 1'b1;
                        end else begin
                            addr_q   <= ld_addr;
                            funct3_q <= ld_funct3;
                            rd_q     <= ld_rd;
                            state    <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        data_q <= ext_data;
                        state  <= S_WB;
                    end
                end
                S_WB:    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decoded from state; A3/WD3 read zero outside the write cycle.
    always_comb begin
        ld_ready = (state == S_IDLE);
        busy     = ~ld_ready;
        mem_req  = (state == S_REQ);
        mem_addr = {addr_q[31:2], 2'b00};
        WE3      = (state == S_WB) && (rd_q != 5'd0);
        A3       = (state == S_WB) ? rd_q : 5'd0;
        WD3      = (state == S_WB) ? data_q : '0;
        ld_err   = err_q;
    end

endmodule

// File: doc/load_writeback_unit.md
LOAD_WRITEBACK_UNIT -- requirements
Module: load_writeback_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports named clk and rst.
REQ-002 Ports SHALL be as follows (name  direction  width  meaning):
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- ld_valid  in  1  load request from decode/ALU.
- ld_ready  out  1  unit idle, can accept a load.
- ld_funct3  in  3  load type (LB=000, LH=001, LW=010, LBU=100, LHU=101).
- ld_addr  in  32  byte address (ALU result).
- ld_rd  in  5  destination register.
- mem_req  out  1  data-memory request.
- mem_gnt  in  1  memory accepted request.
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word.
- WE3  out  1  register-file write enable.
- A3  out  5  register-file write address.
- WD3  out  32  register-file write data.
- busy  out  1  stall to core, equals ~ld_ready.
- ld_err  out  1  one-cycle error pulse.

Function
REQ-003 The FSM SHALL have states IDLE, REQ, WAIT and WB.
REQ-004 In IDLE, ld_ready SHALL be 1, and ld_valid SHALL capture addr, funct3 and rd, then move to REQ.
REQ-005 In REQ, mem_req SHALL be held at 1 with a stable mem_addr until mem_gnt=1, then move to WAIT.
REQ-006 In WAIT, the unit SHALL latch the extended data when mem_rvalid=1 and move to WB; mem_rvalid in any other state SHALL be ignored.
REQ-007 WB SHALL last exactly one cycle with WE3=1, A3=rd and WD3=data, then return to IDLE; WE3 SHALL be 0 in all other states.
REQ-008 If rd=0, the WB cycle SHALL still occur but WE3 SHALL be 0.
REQ-009 Minimum latency SHALL be: accept at cycle 0, mem_req at cycle 1 (gnt the same cycle), rvalid at cycle 2, WE3 at cycle 3.
REQ-010 Lane selection SHALL use addr[1:0]: a byte is taken at offset 8*addr[1:0], and a halfword at offset 16*addr[1].
REQ-011 LB and LH SHALL sign-extend to 32 bits, LBU and LHU SHALL zero-extend, and LW SHALL pass the word through.
REQ-012 Unsupported funct3 (011, 110, 111) SHALL issue no mem_req, pulse ld_err for one cycle, perform no write, and return to IDLE.
REQ-013 ld_valid outside IDLE SHALL be ignored; the producer SHALL hold its request until ld_ready.
REQ-014 A stalled mem_gnt SHALL hold REQ indefinitely with no timeout.

Reset
REQ-015 rst=0 SHALL asynchronously force IDLE, with mem_req=0, WE3=0, A3=0, WD3=0, ld_err=0 and ld_ready=1.
REQ-016 A reset mid-transaction SHALL abandon the transaction, and a later stray mem_rvalid SHALL cause no write.

Configuration
REQ-017 Macro MISALIGN_TRAP_EN defined: LH/LHU with addr[0]=1, or LW with addr[1:0]!=0, SHALL issue no mem_req, pulse ld_err, perform no write, and return to IDLE.
REQ-018 MISALIGN_TRAP_EN undefined: misaligned low address bits SHALL be ignored beyond REQ-010 (LW reads the aligned word), and ld_err SHALL be driven only by REQ-012.

Structure
REQ-019 A shared package load_pkg SHALL hold the state encoding, the funct3 constants and the data width.
REQ-020 A combinational sub-module load_extend (inputs funct3, offset, rdata; output data) SHALL perform lane select and extension.

Verification
REQ-021 LW at addr 0x20, rd=9, rdata 0xDEADBEEF, gnt immediate, rvalid next cycle -> WE3 at cycle 3, A3=9, WD3=0xDEADBEEF, single pulse.
REQ-022 LB at addr 0x43, rdata 0x80123456 -> WD3=0xFFFFFF80; LBU at the same address -> WD3=0x00000080; LHU at 0x42, rdata 0xBEEF0000 -> WD3=0x0000BEEF.
REQ-023 mem_gnt held low for 5 cycles -> mem_req and mem_addr stable for all 5 cycles, busy=1, and no write until after rvalid.
REQ-024 rd=0 LW -> WE3 stays 0, and ld_ready returns after the WB cycle.
REQ-025 rst asserted while in WAIT, then rvalid delivered -> no WE3 and ld_ready=1; funct3=111 -> ld_err pulse, no mem_req.
REQ-026 With MISALIGN_TRAP_EN: LW at 0x22 -> ld_err pulse, no mem_req; without it: mem_addr=0x20 and a normal write.
